// File: rtl/cache_refill_arbiter.sv
// Round-robin refill arbiter: one I/D-cache line read in flight, result pushed into the refill FIFO.
// Optional WAIT-state abort timer enabled by defining REFILL_TIMEOUT_EN.
module cache_refill_arbiter #(
    parameter int FIFO_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_grant,
    input  logic                  dcache_req,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    output logic                  dcache_grant,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic [FIFO_WIDTH-1:0] mem_data,
    input  logic                  fifo_full,
    output logic                  fifo_write_en,
    output logic [FIFO_WIDTH-1:0] fifo_write_data,
    output logic [ADDR_WIDTH-1:0] fifo_write_addr,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;
    typedef enum logic {OWNER_ICACHE, OWNER_DCACHE} owner_t;

    state_t                state, state_next;
    owner_t                last_owner;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [FIFO_WIDTH-1:0] data_r;
    logic                  grant_i_r, grant_d_r;
    logic                  any_req, pick_d, timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign any_req = icache_req | dcache_req;
    // On a tie the requester that did not own the previous refill wins
    assign pick_d  = dcache_req & (~icache_req | (last_owner == OWNER_ICACHE));

`ifdef REFILL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_err_r;

    // A late mem_valid in the expiry cycle takes priority over the abort
    assign timeout_hit = (state == WAIT) & ~mem_valid & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_hit;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if ((state == WAIT) && !mem_valid)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   if (mem_ack) state_next = WAIT;
            WAIT: begin
                if (mem_valid)
                    state_next = PUSH;
                else if (timeout_hit)
                    state_next = IDLE;
            end
            PUSH:    if (!fifo_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWNER_ICACHE;
            addr_r     <= '0;
            data_r     <= '0;
            grant_i_r  <= 1'b0;
            grant_d_r  <= 1'b0;
        end else begin
            state     <= state_next;
            grant_i_r <= 1'b0;
            grant_d_r <= 1'b0;
            if ((state == IDLE) && any_req) begin
                addr_r     <= pick_d ? dcache_addr : icache_addr;
                last_owner <= pick_d ? OWNER_DCACHE : OWNER_ICACHE;
                grant_d_r  <= pick_d;
                grant_i_r  <= ~pick_d;
            end
            if ((state == WAIT) && mem_valid)
                data_r <= mem_data;
        end
    end

    assign icache_grant    = grant_i_r;
    assign dcache_grant    = grant_d_r;
    assign mem_req         = (state == ISSUE);
    assign mem_addr        = mem_req ? addr_r : '0;
    assign fifo_write_en   = (state == PUSH) & ~fifo_full;
    assign fifo_write_data = data_r;
    assign fifo_write_addr = addr_r;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter; status vector is {busy, mem_req, icache_grant, dcache_grant, fifo_write_en, timeout_err}.
module tb_cache_refill_arbiter;

    localparam int FW = 512;
    localparam int AW = 8;
`ifdef REFILL_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_req, dcache_req;
    logic [AW-1:0] icache_addr, dcache_addr;
    logic          icache_grant, dcache_grant;
    logic          mem_req, mem_ack, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [FW-1:0] mem_data;
    logic          fifo_full, fifo_write_en;
    logic [FW-1:0] fifo_write_data;
    logic [AW-1:0] fifo_write_addr;
    logic          busy, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    cache_refill_arbiter #(
        .FIFO_WIDTH(FW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_addr(icache_addr), .icache_grant(icache_grant),
        .dcache_req(dcache_req), .dcache_addr(dcache_addr), .dcache_grant(dcache_grant),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_valid(mem_valid), .mem_data(mem_data),
        .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data), .fifo_write_addr(fifo_write_addr),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] status();
        return {busy, mem_req, icache_grant, dcache_grant, fifo_write_en, timeout_err};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        icache_req = 0; dcache_req = 0; icache_addr = '0; dcache_addr = '0;
        mem_ack = 0; mem_valid = 0; mem_data = '0; fifo_full = 0;
        next_cycle(); next_cycle(); sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL reset_status got=%b exp=%b", status(), 6'b000000); end
        vectors++; if (fifo_write_addr !== 8'h00 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr got=%h/%h exp=00/00", fifo_write_addr, mem_addr); end
        vectors++; if (fifo_write_data !== '0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", fifo_write_data); end
        next_cycle(); reset = 1'b0; sample();
    endtask

    task automatic test_basic();
        logic [FW-1:0] pat;
        pat = {(FW/8){8'hA5}};
        next_cycle(); icache_req = 1; icache_addr = 8'h12; sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL basic_c0 got=%b exp=%b", status(), 6'b000000); end
        next_cycle(); icache_req = 0; mem_ack = 1; sample();
        vectors++; if (status() !== 6'b111000) begin miscompares++; $display("FAIL basic_c1_grant got=%b exp=%b", status(), 6'b111000); end
        vectors++; if (mem_addr !== 8'h12) begin miscompares++; $display("FAIL basic_mem_addr got=%h exp=12", mem_addr); end
        next_cycle(); mem_ack = 0; mem_valid = 1; mem_data = pat; sample();
        vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL basic_c2_wait got=%b exp=%b", status(), 6'b100000); end
        next_cycle(); mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010) begin miscompares++; $display("FAIL basic_c3_push got=%b exp=%b", status(), 6'b100010); end
        vectors++; if (fifo_write_addr !== 8'h12 || fifo_write_data !== pat) begin miscompares++; $display("FAIL basic_c3_payload got=%h exp=12", fifo_write_addr); end
        next_cycle(); sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL basic_c4_idle got=%b exp=%b", status(), 6'b000000); end
    endtask

    task automatic test_round_robin();
        logic          exp_d;
        logic [31:0]   w;
        logic [FW-1:0] pat;
        logic [AW-1:0] exp_addr;
        next_cycle(); icache_req = 1; dcache_req = 1; icache_addr = 8'h01; dcache_addr = 8'h02; sample();
        for (int k = 0; k < 4; k++) begin
            exp_d    = (k % 2 == 0);
            exp_addr = exp_d ? 8'h02 : 8'h01;
            w        = 32'hC0DE0000 + 32'(k);
            pat      = {(FW/32){w}};
            next_cycle(); mem_ack = 1; sample();
            vectors++; if (status() !== {2'b11, ~exp_d, exp_d, 2'b00}) begin miscompares++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, status(), {2'b11, ~exp_d, exp_d, 2'b00}); end
            vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("FAIL rr_mem_addr_%0d got=%h exp=%h", k, mem_addr, exp_addr); end
            next_cycle(); mem_ack = 0; mem_valid = 1; mem_data = pat; sample();
            next_cycle(); mem_valid = 0; sample();
            vectors++; if (status() !== 6'b100010 || fifo_write_addr !== exp_addr) begin miscompares++; $display("FAIL rr_push_%0d got=%b/%h exp=100010/%h", k, status(), fifo_write_addr, exp_addr); end
            vectors++; if (fifo_write_data !== pat) begin miscompares++; $display("FAIL rr_data_%0d got=%h exp=%h", k, fifo_write_data[31:0], w); end
            next_cycle(); if (k == 3) begin icache_req = 0; dcache_req = 0; end sample();
            vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL rr_idle_%0d got=%b exp=%b", k, status(), 6'b000000); end
        end
        next_cycle(); sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL rr_dropped got=%b exp=%b", status(), 6'b000000); end
    endtask

    task automatic test_fifo_full();
        logic [FW-1:0] pat;
        pat = {(FW/8){8'h5A}};
        next_cycle(); icache_req = 1; icache_addr = 8'h33; sample();
        next_cycle(); icache_req = 0; mem_ack = 1; sample();
        vectors++; if (status() !== 6'b111000) begin miscompares++; $display("FAIL full_grant got=%b exp=%b", status(), 6'b111000); end
        next_cycle(); mem_ack = 0; mem_valid = 1; mem_data = pat; sample();
        next_cycle(); mem_valid = 0; mem_data = '0; fifo_full = 1; sample();
        vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL full_hold_0 got=%b exp=%b", status(), 6'b100000); end
        for (int i = 1; i < 5; i++) begin
            next_cycle();
            mem_ack   = (i == 2);
            mem_valid = (i == 2);
            mem_data  = (i == 2) ? {(FW/8){8'hEE}} : '0;
            sample();
            vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL full_hold_%0d got=%b exp=%b", i, status(), 6'b100000); end
            vectors++; if (fifo_write_addr !== 8'h33 || fifo_write_data !== pat) begin miscompares++; $display("FAIL full_held_%0d got=%h exp=33", i, fifo_write_addr); end
        end
        next_cycle(); fifo_full = 0; mem_ack = 0; mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010) begin miscompares++; $display("FAIL full_release got=%b exp=%b", status(), 6'b100010); end
        vectors++; if (fifo_write_data !== pat || fifo_write_addr !== 8'h33) begin miscompares++; $display("FAIL full_payload got=%h exp=33", fifo_write_addr); end
        next_cycle(); sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL full_idle got=%b exp=%b", status(), 6'b000000); end
    endtask

    task automatic test_ack_delay();
        logic [FW-1:0] good;
        good = {(FW/16){16'h1357}};
        next_cycle(); dcache_req = 1; dcache_addr = 8'h44; sample();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 0) dcache_req = 0;
            mem_ack   = (i == 3);
            mem_valid = (i == 1);
            mem_data  = (i == 1) ? {(FW/8){8'hBD}} : '0;
            sample();
            vectors++; if (status() !== {3'b110, (i == 0), 2'b00}) begin miscompares++; $display("FAIL ackdly_issue_%0d got=%b exp=%b", i, status(), {3'b110, (i == 0), 2'b00}); end
            vectors++; if (mem_addr !== 8'h44) begin miscompares++; $display("FAIL ackdly_addr_%0d got=%h exp=44", i, mem_addr); end
        end
        next_cycle(); mem_ack = 0; mem_valid = 1; mem_data = good; sample();
        vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL ackdly_wait got=%b exp=%b", status(), 6'b100000); end
        next_cycle(); mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010 || fifo_write_data !== good) begin miscompares++; $display("FAIL ackdly_push got=%b exp=%b", status(), 6'b100010); end
        next_cycle(); sample();
    endtask

    task automatic test_reset_mid_wait();
        next_cycle(); dcache_req = 1; dcache_addr = 8'h66; sample();
        next_cycle(); dcache_req = 0; mem_ack = 1; sample();
        vectors++; if (status() !== 6'b110100) begin miscompares++; $display("FAIL rstw_grant got=%b exp=%b", status(), 6'b110100); end
        next_cycle(); mem_ack = 0; sample();
        next_cycle(); reset = 1; mem_valid = 1; mem_data = {(FW/8){8'h77}}; #1;
        vectors++; if (status() !== 6'b000000 || fifo_write_addr !== 8'h00 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL rstw_async got=%b/%h exp=000000/00", status(), fifo_write_addr); end
        sample();
        next_cycle(); reset = 0; mem_valid = 0; mem_data = '0; sample();
        next_cycle(); sample();
        vectors++; if (status() !== 6'b000000 || fifo_write_data !== '0) begin miscompares++; $display("FAIL rstw_nowrite got=%b exp=%b", status(), 6'b000000); end
        next_cycle(); icache_req = 1; dcache_req = 1; icache_addr = 8'h0A; dcache_addr = 8'h0B; sample();
        next_cycle(); icache_req = 0; dcache_req = 0; mem_ack = 1; sample();
        vectors++; if (status() !== 6'b110100 || mem_addr !== 8'h0B) begin miscompares++; $display("FAIL rstw_tie got=%b/%h exp=110100/0b", status(), mem_addr); end
        next_cycle(); mem_ack = 0; mem_valid = 1; mem_data = {(FW/8){8'h3C}}; sample();
        next_cycle(); mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010 || fifo_write_addr !== 8'h0B) begin miscompares++; $display("FAIL rstw_push got=%b/%h exp=100010/0b", status(), fifo_write_addr); end
        next_cycle(); sample();
    endtask

    task automatic test_timeout();
        next_cycle(); icache_req = 1; icache_addr = 8'h77; sample();
        next_cycle(); icache_req = 0; mem_ack = 1; sample();
        next_cycle(); mem_ack = 0; sample();
`ifdef REFILL_TIMEOUT_EN
        for (int i = 2; i <= 10; i++) begin
            next_cycle(); sample();
            vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL to_wait_%0d got=%b exp=%b", i, status(), 6'b100000); end
        end
        next_cycle(); icache_req = 1; icache_addr = 8'h78; sample();
        vectors++; if (status() !== 6'b000001) begin miscompares++; $display("FAIL to_pulse got=%b exp=%b", status(), 6'b000001); end
        next_cycle(); icache_req = 0; mem_ack = 1; sample();
        vectors++; if (status() !== 6'b111000 || mem_addr !== 8'h78) begin miscompares++; $display("FAIL to_next_grant got=%b/%h exp=111000/78", status(), mem_addr); end
        next_cycle(); mem_ack = 0; sample();
        for (int i = 2; i <= 10; i++) begin
            next_cycle();
            mem_valid = (i == 10);
            mem_data  = (i == 10) ? {(FW/8){8'h99}} : '0;
            sample();
        end
        next_cycle(); mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010 || fifo_write_addr !== 8'h78) begin miscompares++; $display("FAIL to_valid_wins got=%b/%h exp=100010/78", status(), fifo_write_addr); end
`else
        for (int i = 2; i <= 30; i++) begin
            next_cycle(); sample();
            vectors++; if (status() !== 6'b100000) begin miscompares++; $display("FAIL nto_wait_%0d got=%b exp=%b", i, status(), 6'b100000); end
        end
        next_cycle(); mem_valid = 1; mem_data = {(FW/8){8'h99}}; sample();
        next_cycle(); mem_valid = 0; mem_data = '0; sample();
        vectors++; if (status() !== 6'b100010 || fifo_write_addr !== 8'h77) begin miscompares++; $display("FAIL nto_push got=%b/%h exp=100010/77", status(), fifo_write_addr); end
`endif
        next_cycle(); sample();
        vectors++; if (status() !== 6'b000000) begin miscompares++; $display("FAIL to_idle got=%b exp=%b", status(), 6'b000000); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_fifo_full();
        test_ack_delay();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Shares the single main-memory refill path between the instruction-cache and data-cache miss requesters.
- Arbitrates round-robin and issues one line read to main memory at a time.
- Captures the returned line and pushes {line, address} into the main-to-cache FIFO write port, honouring FIFO full.
- Sits between the two cache miss handlers, the main-memory read interface and the FIFO write side; everything runs in one clock domain.

Parameters:
- FIFO_WIDTH, 512, line width in bits; matches the FIFO data width.
- ADDR_WIDTH, 8, line address width; matches the FIFO address field.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- icache_req  in  1  I-cache miss request; held high until granted.
- icache_addr  in  ADDR_WIDTH  I-cache miss line address; stable while icache_req is high.
- icache_grant  out  1  one-cycle pulse: I-cache request accepted.
- dcache_req  in  1  D-cache miss request; held high until granted.
- dcache_addr  in  ADDR_WIDTH  D-cache miss line address; stable while dcache_req is high.
- dcache_grant  out  1  one-cycle pulse: D-cache request accepted.
- mem_req  out  1  read request to main memory.
- mem_addr  out  ADDR_WIDTH  read address to main memory.
- mem_ack  in  1  main memory accepted mem_req.
- mem_valid  in  1  mem_data is valid this cycle.
- mem_data  in  FIFO_WIDTH  returned line.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  FIFO push strobe.
- fifo_write_data  out  FIFO_WIDTH  line to push.
- fifo_write_addr  out  ADDR_WIDTH  address to push.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  one-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; last_owner=ICACHE; all outputs 0; data/address registers 0. Any in-flight refill is dropped and no FIFO write occurs.
- States: IDLE, ISSUE, WAIT, PUSH.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: select that requester.
  - Both requesting: select the requester that is not last_owner, so after reset D-cache wins the first tie.
  - On selection: latch the requester's address into addr_r and its identity into owner; update last_owner; go to ISSUE.
- ISSUE:
  - Grant for the owner is high for exactly the first cycle of ISSUE.
  - mem_req=1 and mem_addr=addr_r until mem_ack is sampled high; then go to WAIT and drop mem_req on the next cycle.
  - mem_ack is ignored in every state other than ISSUE.
- WAIT:
  - mem_valid high: capture mem_data into data_r; go to PUSH.
  - mem_valid is ignored in every state other than WAIT.
- PUSH:
  - fifo_write_en = (state==PUSH) & ~fifo_full, combinational.
  - fifo_write_data=data_r; fifo_write_addr=addr_r.
  - Go to IDLE on the same edge the write occurs.
  - While fifo_full is high, hold in PUSH indefinitely; data_r and addr_r are held.
- Minimum latency (request at cycle 0, ack in cycle 1, valid in cycle 2):
  - grant at cycle 1;
  - FIFO write at cycle 3;
  - next request accepted at cycle 4 (one refill per 4 cycles maximum).
- A requester dropping req before grant is legal; it is simply not selected. A request arriving while busy waits until IDLE.
- Exactly one refill is outstanding at any time; grants are mutually exclusive and never both high.

Optional Feature:
- Macro REFILL_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on WAIT entry and increments each WAIT cycle without mem_valid.
  - When the count reaches TIMEOUT_CYCLES: timeout_err pulses for 1 cycle, state returns to IDLE, no FIFO write.
  - mem_valid arriving in the same cycle as expiry wins: data is captured and there is no error.
- Not defined: no counter; WAIT waits forever; timeout_err is constant 0.

Test Plan:
- Reset, then icache_req=1 with addr 0x12, mem_ack in cycle 1, mem_valid in cycle 2 with data 0xA5..A5 -> icache_grant at cycle 1; fifo_write_en at cycle 3 with addr 0x12 and data 0xA5..A5.
- Both requesters asserted simultaneously and continuously, addrs 0x01 (I) and 0x02 (D) -> grant order D, I, D, I; FIFO receives addresses 0x02, 0x01, 0x02, 0x01.
- fifo_full=1 when PUSH is entered and held for 5 cycles -> no write while full, busy=1; write fires in the cycle fifo_full drops, then IDLE.
- mem_ack delayed 3 cycles -> mem_req held with a stable mem_addr for 4 cycles; mem_valid pulsed during ISSUE is ignored.
- Reset asserted mid-WAIT -> outputs 0 immediately and no FIFO write; next tie after reset is granted to D-cache.
- With REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=10, mem_valid never asserted -> timeout_err pulse after 10 WAIT cycles, no FIFO write, next request accepted.
